// File: rtl/rat_pkg.sv
// Shared definitions for the program-counter / fetch slice.
// Holds the default address width, the interrupt entry address,
// the load-source selector encoding and the fetch-tracker states.
package rat_pkg;

    // Program address width; the program ROM holds 2**PC_WIDTH words
    localparam int PC_WIDTH = 10;

    // Address the PC jumps to when an interrupt is taken
    localparam logic [PC_WIDTH-1:0] INTR_VECTOR = 10'h3FF;

    // PC load source, encoded exactly as the PC_MUX_SEL input
    typedef enum logic [1:0] {
        SEL_IMMED = 2'd0,
        SEL_STACK = 2'd1,
        SEL_INTR  = 2'd2,
        SEL_ZERO  = 2'd3
    } pc_sel_t;

    // Fetch tracker: tells whether the registered ROM output matches the PC
    typedef enum logic [1:0] {
        F_RESET = 2'd0,
        F_WAIT  = 2'd1,
        F_VALID = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_mux.sv
// PC load-source multiplexer.
// Purely combinational; every selector code drives a defined value so
// nothing unknown can reach the PC register.
module pc_mux
    import rat_pkg::*;
#(
    parameter int                  PC_WIDTH    = rat_pkg::PC_WIDTH,
    parameter logic [PC_WIDTH-1:0] INTR_VECTOR = rat_pkg::INTR_VECTOR
) (
    input  pc_sel_t             sel,
    input  logic [PC_WIDTH-1:0] from_immed,
    input  logic [PC_WIDTH-1:0] from_stack,
    output logic [PC_WIDTH-1:0] mux_out
);

    // Select the load source; the zero default covers any unexpected code
    always_comb begin
        mux_out = '0;
        case (sel)
            SEL_IMMED: mux_out = from_immed;
            SEL_STACK: mux_out = from_stack;
            SEL_INTR:  mux_out = INTR_VECTOR;
            SEL_ZERO:  mux_out = '0;
            default:   mux_out = '0;
        endcase
    end

endmodule

// File: rtl/pc_fetch.sv
// Program counter with load/increment priority, interrupt return-address
// capture, a sticky wrap flag and a fetch tracker that marks when the
// ROM's one-cycle registered read output belongs to the current PC.
module pc_fetch
    import rat_pkg::*;
#(
    parameter int                  PC_WIDTH    = rat_pkg::PC_WIDTH,
    parameter logic [PC_WIDTH-1:0] INTR_VECTOR = rat_pkg::INTR_VECTOR
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                PC_LD,
    input  logic                PC_INC,
    input  logic [1:0]          PC_MUX_SEL,
    input  logic [PC_WIDTH-1:0] FROM_IMMED,
    input  logic [PC_WIDTH-1:0] FROM_STACK,
    output logic [PC_WIDTH-1:0] PC_COUNT,
    output logic                IR_VALID,
    output logic [PC_WIDTH-1:0] SAVED_PC,
    output logic                WRAP
);

    pc_sel_t             sel;
    logic [PC_WIDTH-1:0] mux_out;
    logic [PC_WIDTH-1:0] pc_next;
    logic                inc_wrap;
    logic                pc_change;
    logic                intr_load;
    fetch_state_t        state;
    fetch_state_t        state_nxt;

    assign sel       = pc_sel_t'(PC_MUX_SEL);
    assign intr_load = PC_LD && (sel == SEL_INTR);

    pc_mux #(
        .PC_WIDTH    (PC_WIDTH),
        .INTR_VECTOR (INTR_VECTOR)
    ) u_pc_mux (
        .sel        (sel),
        .from_immed (FROM_IMMED),
        .from_stack (FROM_STACK),
        .mux_out    (mux_out)
    );

    // Next PC: load beats increment beats hold; flag an increment rollover
    always_comb begin
        pc_next  = PC_COUNT;
        inc_wrap = 1'b0;
        if (PC_LD) begin
            pc_next = mux_out;
        end else if (PC_INC) begin
            pc_next  = PC_COUNT + PC_WIDTH'(1);
            inc_wrap = &PC_COUNT;
        end
        // A load or increment landing on the same value is not a change
        pc_change = (pc_next != PC_COUNT);
    end

    // PC register; reset overrides any load or increment at the same edge
    always_ff @(posedge CLK) begin
        if (RST) begin
            PC_COUNT <= '0;
        end else begin
            PC_COUNT <= pc_next;
        end
    end

    // Return-address capture on interrupt entry and sticky wrap flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            SAVED_PC <= '0;
            WRAP     <= 1'b0;
        end else begin
            if (intr_load) begin
                SAVED_PC <= PC_COUNT;
            end
            if (inc_wrap) begin
                WRAP <= 1'b1;
            end
        end
    end

    // Fetch tracker state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= F_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    // Fetch tracker transitions: any PC change costs one ROM read cycle
    always_comb begin
        state_nxt = state;
        case (state)
            F_RESET: state_nxt = F_WAIT;
            F_WAIT:  state_nxt = pc_change ? F_WAIT : F_VALID;
            F_VALID: state_nxt = pc_change ? F_WAIT : F_VALID;
            default: state_nxt = F_RESET;
        endcase
    end

    // Instruction register is valid only once the ROM has caught up
    always_comb begin
        IR_VALID = (state == F_VALID);
    end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter PC_WIDTH, default 10, program address width; matches the 1024-word program ROM.
REQ-002 Parameter INTR_VECTOR, default 10'h3FF, interrupt service entry address.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 PC_LD  input  1  load the PC from the source chosen by PC_MUX_SEL.
REQ-006 PC_INC  input  1  increment the PC by one.
REQ-007 PC_MUX_SEL  input  2  load source: 0 FROM_IMMED, 1 FROM_STACK, 2 INTR_VECTOR, 3 10'h000.
REQ-008 FROM_IMMED  input  10  branch/call target from the instruction immediate field.
REQ-009 FROM_STACK  input  10  return address popped from the stack.
REQ-010 PC_COUNT  output  10  current PC; drives the program ROM address input directly.
REQ-011 IR_VALID  output  1  high when the registered ROM instruction output corresponds to PC_COUNT.
REQ-012 SAVED_PC  output  10  PC captured on interrupt vector load, for RETI.
REQ-013 WRAP  output  1  sticky flag: an increment wrapped 10'h3FF to 10'h000.

Function
REQ-014 The PC register SHALL follow this priority: RST, then PC_LD, then PC_INC, then hold.
REQ-015 When PC_LD and PC_INC are both high, the load SHALL win and the increment SHALL be discarded.
REQ-016 A load SHALL take effect at the same edge: PC_COUNT equals the selected source in the following cycle (latency 1).
REQ-017 An increment SHALL be modulo 2^PC_WIDTH: 10'h3FF+1 gives 10'h000 and sets WRAP.
REQ-018 WRAP SHALL be set only by an increment wrap; a load of 10'h000 SHALL NOT set it; it SHALL clear only on RST.
REQ-019 A load with PC_MUX_SEL=2 SHALL capture the pre-load PC_COUNT into SAVED_PC at the same edge; SAVED_PC SHALL hold otherwise.
REQ-020 A load with PC_MUX_SEL=2 while PC_COUNT already equals INTR_VECTOR SHALL still capture SAVED_PC, which then equals INTR_VECTOR.
REQ-021 The fetch tracker SHALL be an FSM with states F_RESET, F_WAIT and F_VALID, driving IR_VALID high only in F_VALID.
REQ-022 F_RESET: entered on RST from any state; on the first edge with RST low it SHALL go to F_WAIT.
REQ-023 F_WAIT: on the next edge it SHALL go to F_VALID if the PC does not change at that edge, and otherwise stay in F_WAIT.
REQ-024 F_VALID: on any edge where the PC register changes value, it SHALL go to F_WAIT.
REQ-025 A load or increment that leaves PC_COUNT numerically unchanged SHALL NOT leave F_VALID.
REQ-026 Net effect of the fetch tracker: IR_VALID is low for exactly one cycle after each PC change, matching the ROM's one-cycle registered read.
REQ-027 Every PC_MUX_SEL value SHALL be defined, so there are no X-propagating mux inputs.

Reset
REQ-028 While RST is high at an edge: PC_COUNT SHALL be 10'h000, SAVED_PC 10'h000, WRAP 0, FSM F_RESET, IR_VALID 0.
REQ-029 RST asserted mid-operation, including while PC_LD or PC_INC is high, SHALL override that operation at the same edge.
REQ-030 The block SHALL have no asynchronous reset path and no initial-value dependence.

Structure
REQ-031 A shared package rat_pkg SHALL hold PC_WIDTH and INTR_VECTOR.
REQ-032 rat_pkg SHALL hold the pc_sel_t enum (SEL_IMMED, SEL_STACK, SEL_INTR, SEL_ZERO).
REQ-033 rat_pkg SHALL hold the fetch_state_t enum (F_RESET, F_WAIT, F_VALID).
REQ-034 The source mux SHALL be a combinational sub-module, pc_mux; the register, flags and FSM SHALL live in pc_fetch.

Verification
REQ-035 Reset then increment: RST high for 2 cycles, then PC_INC=1 for 3 cycles -> PC_COUNT 0,1,2,3; IR_VALID 0 after each step, 1 once PC_INC drops.
REQ-036 Load priority: PC_LD=1, PC_INC=1, SEL=0, FROM_IMMED=10'h155 -> PC_COUNT=10'h155 next cycle, not 10'h001.
REQ-037 Interrupt: PC_COUNT=10'h0A7, PC_LD=1, SEL=2 -> PC_COUNT=10'h3FF, SAVED_PC=10'h0A7; then SEL=1, FROM_STACK=10'h0A7 -> PC_COUNT=10'h0A7.
REQ-038 Wrap: PC_COUNT=10'h3FF, PC_INC=1 -> PC_COUNT=10'h000, WRAP=1; then load 10'h000 -> WRAP stays 1 until RST.
REQ-039 Reset mid-load: PC_LD=1, SEL=0, FROM_IMMED=10'h200 with RST=1 at the same edge -> PC_COUNT=10'h000, IR_VALID=0.
REQ-040 ROM coupling: with a ROM model holding rom[n]=n, whenever IR_VALID=1 the ROM output SHALL equal PC_COUNT, checked over 1000 random cycles.
